gps_rom_lookup_arbiter: RTL
===========================

// Module: gps_rom_lookup_arbiter
// PURPOSE
//  Shares one interpolation ROM port (COS or ASIN table) between two lookup requesters in the GPS distance datapath.
//  Per granted request: linear scan from address 0 for the first entry whose key field is strictly above the request key.
//  Returns the bracketing entries lo (previous) and hi (match) for downstream linear interpolation.
//  Sits between the point-A/point-B front end and the table ROM; owns rom_addr.
// PARAMETERS
//  KEY_W   24   request key width (lat/lon fixed-point)
//  X_W     48   x field width; x = rom_data[ENT_W-1:Y_W]
//  Y_W     48   y field width; y = rom_data[Y_W-1:0]
//  KEY_LSB 16   compared key = x[KEY_LSB+KEY_W-1:KEY_LSB]
//  AW      7    ROM address width
//  DEPTH   128  valid entries, addresses 0..DEPTH-1; DEPTH <= 2**AW
//  ENT_W = X_W+Y_W (local)
// PORTS
//  clk       in   1          clock, rising edge
//  reset_n   in   1          async active-low reset
//  req       in   2          lookup request per requester; held high with key stable until done
//  key       in   2*KEY_W    packed keys; requester i at [i*KEY_W +: KEY_W]
//  rom_addr  out  AW         registered ROM address
//  rom_data  in   ENT_W      ROM word for the current rom_addr (combinational ROM, same cycle)
//  busy      out  1          scan in progress
//  gnt       out  2          requester(s) currently being served
//  done      out  2          1-cycle pulse per requester; lo/hi/clamp valid in that cycle
//  clamp     out  2          with done: key below entry 0 or not below entry DEPTH-1
//  lo_ent    out  2*ENT_W    packed lower bracket entry per requester
//  hi_ent    out  2*ENT_W    packed upper bracket entry per requester
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr=0, busy=0, gnt=0, done=0, clamp=0, lo_ent=0, hi_ent=0; rr pointer = requester 0.
//  FSM: IDLE -> SCAN -> IDLE. No other states.
//  IDLE:
//   - If any req is high: latch the key(s), set gnt, rom_addr<=0, busy<=1, go to SCAN (grant cycle = cycle 0).
//   - Single request: grant it.
//   - Both requests: grant the rr-pointer side; the pointer flips to the other side after each grant.
//  SCAN, per cycle at address k, per served requester:
//   - Match when x-key > latched key (unsigned, strict).
//   - Match at k>0: hi=rom_data, lo=entry k-1 (held in a prev register), clamp=0.
//   - Match at k=0: lo=hi=entry 0, clamp=1.
//   - No match and k=DEPTH-1: lo=hi=entry DEPTH-1, clamp=1.
//   - No match otherwise: prev<=rom_data, rom_addr<=k+1.
//  done[i], lo/hi/clamp registered: asserted in the cycle after the match cycle.
//   - Latency: done at cycle k+2 after the grant cycle; worst case DEPTH+1.
//  After the final done: rom_addr<=0, busy<=0, gnt<=0, back to IDLE.
//   - A new grant is possible in the cycle done is high (back-to-back requests).
//  Requester protocol:
//   - Drop req in the cycle after done, or keep it high to issue a new lookup.
//   - The arbiter does not re-sample req/key during SCAN; a drop mid-scan is ignored and done still pulses.
//  lo_ent/hi_ent/clamp hold their last values until overwritten; only done marks them valid.
//  Reset mid-scan: immediate abort to reset values; no done is issued for the aborted scan.
//  rom_addr never exceeds DEPTH-1; no wrap-around.
// CONFIGURATION
//  GPS_SHARED_SCAN_EN defined:
//   - When both req are high in IDLE, both are granted (gnt=2'b11) and served by a single scan.
//   - Each side keeps its own found flag and prev register; each done pulses independently the cycle after its own match.
//   - The scan continues until both sides have matched; the rr pointer does not change.
//  GPS_SHARED_SCAN_EN undefined: one requester per scan; strict round-robin as above.
// TESTING
//  ROM entry i key field = (i+1)*0x1000; y = i.
//  1. req0 with key 0x002800 -> done[0] at cycle 4; lo=entry 1, hi=entry 2, clamp=0.
//  2. Key 0x002000 (equal) -> hi=entry 2, lo=entry 1 (strict compare); key 0x000800 -> lo=hi=entry 0, clamp=1, done at cycle 2.
//  3. Key 0xFFFFFF -> lo=hi=entry 127, clamp=1, done at cycle 129; rom_addr peaks at 127.
//  4. Both req, keys 0x004800/0x001800, macro off:
//     - req0 is served first: done[0] at cycle 6.
//     - req1 is granted next in the IDLE cycle that follows.
//     - Repeat the pair: req1 is served first.
//  5. Same as 4 with GPS_SHARED_SCAN_EN: one scan, done[1] at cycle 3, done[0] at cycle 6, gnt=2'b11 throughout.
//  6. Assert reset_n low at scan cycle 10 -> all outputs go to 0 immediately; no done.
//     After release, a fresh req0 completes normally.

Source files
------------

// File: rtl/gps_rom_lookup_arbiter.sv
// Two-requester arbiter sharing one interpolation ROM; scans for the first entry whose key is above the request key.
// Optional GPS_SHARED_SCAN_EN: simultaneous requests share a single scan instead of round-robin.
module gps_rom_lookup_arbiter #(
    parameter int KEY_W   = 24,
    parameter int X_W     = 48,
    parameter int Y_W     = 48,
    parameter int KEY_LSB = 16,
    parameter int AW      = 7,
    parameter int DEPTH   = 128
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             req,
    input  logic [2*KEY_W-1:0]     key,
    output logic [AW-1:0]          rom_addr,
    input  logic [X_W+Y_W-1:0]     rom_data,
    output logic                   busy,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic [1:0]             clamp,
    output logic [2*(X_W+Y_W)-1:0] lo_ent,
    output logic [2*(X_W+Y_W)-1:0] hi_ent
);
    localparam int ENT_W = X_W + Y_W;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state;
    logic [1:0][KEY_W-1:0]   key_q;
    logic [1:0][ENT_W-1:0]   prev;
    logic [1:0]              found;
    logic                    rr;

    logic [KEY_W-1:0]        x_key;
    logic                    at_zero, at_last, scan_end, rr_flip;
    logic [1:0]              match, fin, gnt_n;

    always_comb begin
        x_key   = rom_data[Y_W+KEY_LSB +: KEY_W];
        at_zero = (rom_addr == '0);
        at_last = (rom_addr == AW'(DEPTH-1));
        for (int i = 0; i < 2; i++) begin
            match[i] = gnt[i] & ~found[i] & (x_key > key_q[i]);
            fin[i]   = gnt[i] & ~found[i] & (match[i] | at_last);
        end
        // Scan ends once every granted side has matched (now or earlier).
        scan_end = &(found | fin | ~gnt);
        gnt_n    = req;
        rr_flip  = 1'b0;
`ifdef GPS_SHARED_SCAN_EN
        rr_flip  = 1'b0;
`else
        // Pointer only moves on a contested grant, so an uncontested follow-up keeps the other side's turn.
        if (&req) begin
            gnt_n   = rr ? 2'b10 : 2'b01;
            rr_flip = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            busy     <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            clamp    <= '0;
            lo_ent   <= '0;
            hi_ent   <= '0;
            key_q    <= '0;
            prev     <= '0;
            found    <= '0;
            rr       <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= gnt_n;
                        key_q    <= key;
                        found    <= '0;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                        if (rr_flip) rr <= ~rr;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    for (int i = 0; i < 2; i++) begin
                        if (fin[i]) begin
                            done[i]                   <= 1'b1;
                            found[i]                  <= 1'b1;
                            hi_ent[i*ENT_W +: ENT_W]  <= rom_data;
                            lo_ent[i*ENT_W +: ENT_W]  <= (match[i] && !at_zero) ? prev[i] : rom_data;
                            clamp[i]                  <= !(match[i] && !at_zero);
                        end else begin
                            prev[i] <= rom_data;
                        end
                    end
                    if (scan_end) begin
                        rom_addr <= '0;
                        busy     <= 1'b0;
                        gnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
